data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  data_mem_arbiter
//  Two-port data-memory arbiter: single-cycle stores, one outstanding load.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p1_req,
   input  logic [7:0]  p0_addr,
   input  logic [7:0]  p1_addr,
   input  logic [31:0] p0_wdata,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p0_mask,
   input  logic [3:0]  p1_mask,
   input  logic        p0_we,
   input  logic        p1_we,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        p0_rvalid,
   output logic        p1_rvalid,
   output logic [31:0] p0_rdata,
   output logic [31:0] p1_rdata,
   output logic        err,
   output logic        mem_request,
   output logic        mem_we_re,
   output logic        mem_load,
   output logic [7:0]  mem_address,
   output logic [31:0] mem_w_data,
   output logic [3:0]  mem_masking,
   input  logic        mem_valid,
   input  logic [31:0] mem_r_data
);

   // Last counter value before the load is declared timed out
   localparam logic [3:0] c_cnt_last = 4'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic        r_owner;
   logic [3:0]  r_cnt;

   logic        w_win;
   logic        w_idle_req;
   logic        w_we;
   logic        w_wait;
   logic        w_hit;
   logic        w_tmo;
   logic        w_fin;

   always_comb begin
      w_win = 1'b0;
      if (p0_req && p1_req)
         w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
      else
         w_win = p1_req;

      // Outputs are gated by rst so everything reads 0 while reset is held
      w_idle_req = rst && (r_state == IDLE) && (p0_req || p1_req);
      w_we       = w_win ? p1_we : p0_we;

      p0_gnt      = w_idle_req && !w_win;
      p1_gnt      = w_idle_req && w_win;
      mem_request = w_idle_req;
      mem_we_re   = w_idle_req && w_we;
      mem_load    = w_idle_req && !w_we;
      mem_address = w_idle_req ? (w_win ? p1_addr  : p0_addr)  : 8'h00;
      mem_w_data  = w_idle_req ? (w_win ? p1_wdata : p0_wdata) : 32'h0;
      mem_masking = w_idle_req ? (w_win ? p1_mask  : p0_mask)  : 4'h0;

      w_wait = rst && (r_state == WAIT_RD);
      w_hit  = w_wait && mem_valid;
      w_tmo  = w_wait && !mem_valid && (r_cnt == c_cnt_last);
      w_fin  = w_hit || w_tmo;

      p0_rvalid = w_fin && !r_owner;
      p1_rvalid = w_fin && r_owner;
      p0_rdata  = (w_hit && !r_owner) ? mem_r_data : 32'h0;
      p1_rdata  = (w_hit && r_owner)  ? mem_r_data : 32'h0;
      err       = w_tmo;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_cnt        <= 4'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_idle_req) begin
                  r_last_grant <= w_win;
                  if (!w_we) begin
                     r_owner <= w_win;
                     r_cnt   <= 4'h0;
                     r_state <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (w_fin)
                  r_state <= IDLE;
               else
                  r_cnt <= r_cnt + 4'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  tb_data_mem_arbiter
//  Directed vector bench for data_mem_arbiter (round-robin and fixed-priority).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

   typedef struct packed {
      logic        req0, we0;
      logic [7:0]  addr0;
      logic [31:0] wd0;
      logic [3:0]  mk0;
      logic        req1, we1;
      logic [7:0]  addr1;
      logic [31:0] wd1;
      logic [3:0]  mk1;
      logic        mv;
      logic [31:0] mrd;
   } in_t;

   typedef struct packed {
      logic        gnt0, gnt1, rv0, rv1;
      logic [31:0] rd0, rd1;
      logic        err, mreq, mwe, mld;
      logic [7:0]  maddr;
      logic [31:0] mwd;
      logic [3:0]  mmask;
   } out_t;

   typedef struct packed {
      in_t        i;
      out_t       o;
      logic [1:0] fg;   // expected {p0_gnt, p1_gnt} of the fixed-priority instance
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p1_req, p0_we, p1_we, mem_valid;
   logic [7:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata, mem_r_data;
   logic [3:0]  p0_mask, p1_mask;

   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, err;
   logic        mem_request, mem_we_re, mem_load;
   logic [31:0] p0_rdata, p1_rdata, mem_w_data;
   logic [7:0]  mem_address;
   logic [3:0]  mem_masking;

   logic        f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid, f_err;
   logic        f_mem_request, f_mem_we_re, f_mem_load;
   logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_w_data;
   logic [7:0]  f_mem_address;
   logic [3:0]  f_mem_masking;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4)) u_rr (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_mask(p0_mask), .p1_mask(p1_mask),
      .p0_we(p0_we), .p1_we(p1_we), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
      .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .err(err), .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
      .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_masking(mem_masking),
      .mem_valid(mem_valid), .mem_r_data(mem_r_data)
   );

   data_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4)) u_fix (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_mask(p0_mask), .p1_mask(p1_mask),
      .p0_we(p0_we), .p1_we(p1_we), .p0_gnt(f_p0_gnt), .p1_gnt(f_p1_gnt),
      .p0_rvalid(f_p0_rvalid), .p1_rvalid(f_p1_rvalid), .p0_rdata(f_p0_rdata), .p1_rdata(f_p1_rdata),
      .err(f_err), .mem_request(f_mem_request), .mem_we_re(f_mem_we_re), .mem_load(f_mem_load),
      .mem_address(f_mem_address), .mem_w_data(f_mem_w_data), .mem_masking(f_mem_masking),
      .mem_valid(mem_valid), .mem_r_data(mem_r_data)
   );

   out_t act;
   assign act = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, err,
                 mem_request, mem_we_re, mem_load, mem_address, mem_w_data, mem_masking};

   function automatic in_t pin(logic r0, logic w0, logic [7:0] a0, logic [31:0] d0, logic [3:0] m0,
                               logic r1, logic w1, logic [7:0] a1, logic [31:0] d1, logic [3:0] m1,
                               logic mv, logic [31:0] mr);
      in_t x;
      x = '{r0, w0, a0, d0, m0, r1, w1, a1, d1, m1, mv, mr};
      return x;
   endfunction

   function automatic out_t gr(logic port, logic we, logic [7:0] a, logic [31:0] d, logic [3:0] m);
      out_t x;
      x       = '0;
      x.gnt0  = ~port;
      x.gnt1  = port;
      x.mreq  = 1'b1;
      x.mwe   = we;
      x.mld   = ~we;
      x.maddr = a;
      x.mwd   = d;
      x.mmask = m;
      return x;
   endfunction

   function automatic out_t rv(logic port, logic [31:0] d, logic e);
      out_t x;
      x     = '0;
      x.rv0 = ~port;
      x.rv1 = port;
      x.rd0 = port ? 32'h0 : d;
      x.rd1 = port ? d : 32'h0;
      x.err = e;
      return x;
   endfunction

   task automatic drive(input in_t x);
      p0_req = x.req0; p0_we = x.we0; p0_addr = x.addr0; p0_wdata = x.wd0; p0_mask = x.mk0;
      p1_req = x.req1; p1_we = x.we1; p1_addr = x.addr1; p1_wdata = x.wd1; p1_mask = x.mk1;
      mem_valid = x.mv; mem_r_data = x.mrd;
   endtask

   task automatic chk(input string name, input out_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_fix(input string name, input logic [1:0] exp);
      n_chk++;
      if ({f_p0_gnt, f_p1_gnt} !== exp) begin
         n_fail++;
         $display("FAIL %s: fixed-prio gnt got %b expected %b", name, {f_p0_gnt, f_p1_gnt}, exp);
      end
   endtask

   // Drive just after the edge, compare mid-cycle, then advance to the next edge
   task automatic cyc(input in_t x, input string name, input out_t exp);
      drive(x);
      #3;
      chk(name, exp);
      @(posedge clk);
      #1;
   endtask

   localparam int NV = 15;
   vec_t tbl [NV];

   initial begin
      in_t  none;
      in_t  both;
      out_t z;
      none = '0;
      z    = '0;
      both = pin(1, 1, 8'h01, 32'h1111_1111, 4'h1, 1, 1, 8'h02, 32'h2222_2222, 4'h2, 0, 32'h0);

      tbl[0]  = '{none, z, 2'b00};
      tbl[1]  = '{both, gr(0, 1, 8'h01, 32'h1111_1111, 4'h1), 2'b10};
      tbl[2]  = '{both, gr(1, 1, 8'h02, 32'h2222_2222, 4'h2), 2'b10};
      tbl[3]  = '{both, gr(0, 1, 8'h01, 32'h1111_1111, 4'h1), 2'b10};
      tbl[4]  = '{both, gr(1, 1, 8'h02, 32'h2222_2222, 4'h2), 2'b10};
      tbl[5]  = '{pin(1, 1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0, 0, 32'h0),
                  gr(0, 1, 8'h10, 32'hDEAD_BEEF, 4'hF), 2'b10};
      tbl[6]  = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 0, 8'h10, 32'h0, 4'hF, 0, 32'h0),
                  gr(1, 0, 8'h10, 32'h0, 4'hF), 2'b01};
      tbl[7]  = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hDEAD_BEEF),
                  rv(1, 32'hDEAD_BEEF, 0), 2'b00};
      tbl[8]  = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 1, 32'h1234_5678),
                  z, 2'b00};
      tbl[9]  = '{pin(1, 0, 8'h20, 32'h0, 4'h3, 0, 0, 8'h00, 32'h0, 4'h0, 0, 32'h0),
                  gr(0, 0, 8'h20, 32'h0, 4'h3), 2'b10};
      tbl[10] = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h30, 32'hCAFE_F00D, 4'hC, 0, 32'h0),
                  z, 2'b00};
      tbl[11] = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h30, 32'hCAFE_F00D, 4'hC, 1, 32'hA5A5_A5A5),
                  rv(0, 32'hA5A5_A5A5, 0), 2'b00};
      tbl[12] = '{pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h30, 32'hCAFE_F00D, 4'hC, 0, 32'h0),
                  gr(1, 1, 8'h30, 32'hCAFE_F00D, 4'hC), 2'b01};
      tbl[13] = '{pin(1, 1, 8'h40, 32'h0000_0040, 4'hF, 1, 1, 8'h50, 32'h0000_0050, 4'h1, 0, 32'h0),
                  gr(0, 1, 8'h40, 32'h0000_0040, 4'hF), 2'b10};
      tbl[14] = '{pin(1, 1, 8'h40, 32'h0000_0040, 4'hF, 1, 1, 8'h50, 32'h0000_0050, 4'h1, 0, 32'h0),
                  gr(1, 1, 8'h50, 32'h0000_0050, 4'h1), 2'b10};

      // Reset held with requests present: every output must stay 0
      rst = 1'b0;
      drive(both);
      #3;
      chk("reset_outputs", z);
      chk_fix("reset_fixed", 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int k = 0; k < NV; k++) begin
         drive(tbl[k].i);
         #3;
         chk($sformatf("vec%0d", k), tbl[k].o);
         chk_fix($sformatf("vec%0d_fix", k), tbl[k].fg);
         @(posedge clk);
         #1;
      end

      // Load timeout: garbage on mem_r_data must not leak into rdata
      cyc(pin(1, 0, 8'h60, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'h0, 0, 32'h0),
          "tmo_grant", gr(0, 0, 8'h60, 32'h0, 4'hF));
      for (int c = 1; c <= 3; c++)
         cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 0, 32'hFFFF_FFFF),
             $sformatf("tmo_wait%0d", c), z);
      cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h70, 32'h7777_7777, 4'h7, 0, 32'hFFFF_FFFF),
          "tmo_fire", rv(0, 32'h0, 1));
      cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h70, 32'h7777_7777, 4'h7, 0, 32'h0),
          "tmo_back_idle", gr(1, 1, 8'h70, 32'h7777_7777, 4'h7));

      // Reset in the cycle after a load grant aborts the load
      cyc(pin(1, 0, 8'h80, 32'h0, 4'h1, 0, 0, 8'h00, 32'h0, 4'h0, 0, 32'h0),
          "rst_load_grant", gr(0, 0, 8'h80, 32'h0, 4'h1));
      rst = 1'b0;
      cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 1, 1, 8'h90, 32'h9, 4'h9, 1, 32'hBBBB_BBBB),
          "rst_mid_load", z);
      rst = 1'b1;
      cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hBBBB_BBBB),
          "rst_late_valid", z);
      cyc(pin(0, 0, 8'h00, 32'h0, 4'h0, 0, 0, 8'h00, 32'h0, 4'h0, 1, 32'hCCCC_CCCC),
          "rst_late_valid2", z);
      // After reset last_grant is port 1 again, so port 0 wins the conflict
      cyc(both, "rst_rr_restart", gr(0, 1, 8'h01, 32'h1111_1111, 4'h1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
